// File: rtl/ascon_ctrl_fsm_gen.sv
// Control FSM for the ASCON AEAD core: sequences initialisation, a variable number of
// associated-data and text blocks with a valid/ready handshake, and finalisation.
module ascon_ctrl_fsm_gen #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6,
  parameter int unsigned BLK_W    = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             decrypt_i,
  input  logic [BLK_W-1:0] nb_ad_i,
  input  logic [BLK_W-1:0] nb_pt_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             busy_o,
  output logic [3:0]       round_o,
  output logic             data_sel_o,
  output logic             en_reg_state_o,
  output logic             en_xor_data_begin_o,
  output logic             en_replace_o,
  output logic             en_xor_key_begin_o,
  output logic             en_xor_key_end_o,
  output logic             en_xor_lsb_end_o,
  output logic             en_cipher_o,
  output logic             cipher_valid_o,
  output logic             en_tag_o,
  output logic             end_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StInit   = 3'd1;
  localparam logic [2:0] StAdWait = 3'd2;
  localparam logic [2:0] StAdRnd  = 3'd3;
  localparam logic [2:0] StPtWait = 3'd4;
  localparam logic [2:0] StPtRnd  = 3'd5;
  localparam logic [2:0] StFinRnd = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  // Round-constant index of the first round of each permutation flavour.
  localparam logic [3:0] BaseA = 4'(12 - ROUNDS_A);
  localparam logic [3:0] BaseB = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LastA = 4'(ROUNDS_A - 1);
  localparam logic [3:0] LastB = 4'(ROUNDS_B - 1);
  localparam logic [BLK_W-1:0] One = BLK_W'(1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] nb_ad_q, nb_ad_d;
  logic [BLK_W-1:0] nb_pt_q, nb_pt_d;
  logic             dec_q, dec_d;
  logic             cv_q, cv_d;

  logic last_ad, last_pt;
  logic ad_end, pt_end, fin_end;

  assign last_ad = (blk_q == nb_ad_q - One);
  assign last_pt = (blk_q == nb_pt_q - One);

  // Next-state, counter updates and output decode.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    blk_d    = blk_q;
    nb_ad_d  = nb_ad_q;
    nb_pt_d  = nb_pt_q;
    dec_d    = dec_q;
    cv_d     = 1'b0;
    ad_end   = 1'b0;
    pt_end   = 1'b0;
    fin_end  = 1'b0;

    data_ready_o        = 1'b0;
    round_o             = 4'd0;
    data_sel_o          = 1'b0;
    en_reg_state_o      = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_replace_o        = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    end_o               = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          dec_d   = decrypt_i;
          nb_ad_d = nb_ad_i;
          // A zero text count still carries the final padded block.
          nb_pt_d = (nb_pt_i == '0) ? One : nb_pt_i;
          rnd_d   = 4'd0;
          blk_d   = '0;
          state_d = StInit;
        end
      end

      StInit: begin
        en_reg_state_o = 1'b1;
        round_o        = BaseA + rnd_q;
        data_sel_o     = (rnd_q != 4'd0);
        if (rnd_q == LastA) begin
          en_xor_key_end_o = 1'b1;
          rnd_d            = 4'd0;
          if (nb_ad_q == '0) begin
            en_xor_lsb_end_o = 1'b1;
            state_d          = StPtWait;
          end else begin
            state_d = StAdWait;
          end
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      StAdWait: begin
        data_ready_o = 1'b1;
        data_sel_o   = 1'b1;
        round_o      = BaseB;
        if (data_valid_i) begin
          en_xor_data_begin_o = 1'b1;
          en_reg_state_o      = 1'b1;
          if (ROUNDS_B == 1) begin
            ad_end = 1'b1;
          end else begin
            rnd_d   = 4'd1;
            state_d = StAdRnd;
          end
        end
      end

      StAdRnd: begin
        data_sel_o     = 1'b1;
        en_reg_state_o = 1'b1;
        round_o        = BaseB + rnd_q;
        if (rnd_q == LastB) ad_end = 1'b1;
        else                rnd_d  = rnd_q + 4'd1;
      end

      StPtWait: begin
        data_ready_o = 1'b1;
        data_sel_o   = 1'b1;
        round_o      = last_pt ? BaseA : BaseB;
        if (data_valid_i) begin
          en_xor_data_begin_o = ~dec_q;
          en_replace_o        = dec_q;
          en_cipher_o         = 1'b1;
          en_reg_state_o      = 1'b1;
          cv_d                = 1'b1;
          if (last_pt) begin
            en_xor_key_begin_o = 1'b1;
            if (ROUNDS_A == 1) begin
              fin_end = 1'b1;
            end else begin
              rnd_d   = 4'd1;
              state_d = StFinRnd;
            end
          end else if (ROUNDS_B == 1) begin
            pt_end = 1'b1;
          end else begin
            rnd_d   = 4'd1;
            state_d = StPtRnd;
          end
        end
      end

      StPtRnd: begin
        data_sel_o     = 1'b1;
        en_reg_state_o = 1'b1;
        round_o        = BaseB + rnd_q;
        if (rnd_q == LastB) pt_end = 1'b1;
        else                rnd_d  = rnd_q + 4'd1;
      end

      StFinRnd: begin
        data_sel_o     = 1'b1;
        en_reg_state_o = 1'b1;
        round_o        = BaseA + rnd_q;
        if (rnd_q == LastA) fin_end = 1'b1;
        else                rnd_d   = rnd_q + 4'd1;
      end

      StDone: begin
        end_o   = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // End-of-block actions, shared by the accept cycle and the last round cycle.
    if (ad_end) begin
      rnd_d = 4'd0;
      if (last_ad) begin
        en_xor_lsb_end_o = 1'b1;
        blk_d            = '0;
        state_d          = StPtWait;
      end else begin
        blk_d   = blk_q + One;
        state_d = StAdWait;
      end
    end
    if (pt_end) begin
      rnd_d   = 4'd0;
      blk_d   = blk_q + One;
      state_d = StPtWait;
    end
    if (fin_end) begin
      en_xor_key_end_o = 1'b1;
      en_tag_o         = 1'b1;
      rnd_d            = 4'd0;
      state_d          = StDone;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign cipher_valid_o = cv_q;

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
      nb_ad_q <= '0;
      nb_pt_q <= '0;
      dec_q   <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      nb_ad_q <= nb_ad_d;
      nb_pt_q <= nb_pt_d;
      dec_q   <= dec_d;
      cv_q    <= cv_d;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm_gen.sv
// Directed bench for ascon_ctrl_fsm_gen: one instance with A=12/B=6, one with A=8/B=4,
// both driven by the same stimulus; per-cycle output traces are checked against tables.
module tb_ascon_ctrl_fsm_gen;

  localparam int BEnd = 4, BTag = 5, BCv = 6, BCip = 7, BLsb = 8, BKe = 9, BKb = 10;
  localparam int BRep = 11, BXdb = 12, BReg = 13, BSel = 14, BRdy = 15, BBusy = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, dec, valid;
  logic [3:0] nad, npt;

  logic        a_rdy, a_busy, a_sel, a_reg, a_xdb, a_rep, a_kb, a_ke, a_lsb, a_cip, a_cv;
  logic        a_tag, a_end;
  logic [3:0]  a_rnd;
  logic        b_rdy, b_busy, b_sel, b_reg, b_xdb, b_rep, b_kb, b_ke, b_lsb, b_cip, b_cv;
  logic        b_tag, b_end;
  logic [3:0]  b_rnd;
  logic [16:0] obs_a, obs_b;
  logic [16:0] ta [0:63];
  logic [16:0] tbb [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_ctrl_fsm_gen #(.ROUNDS_A(12), .ROUNDS_B(6), .BLK_W(4)) u_dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start), .decrypt_i(dec), .nb_ad_i(nad),
    .nb_pt_i(npt), .data_valid_i(valid), .data_ready_o(a_rdy), .busy_o(a_busy),
    .round_o(a_rnd), .data_sel_o(a_sel), .en_reg_state_o(a_reg),
    .en_xor_data_begin_o(a_xdb), .en_replace_o(a_rep), .en_xor_key_begin_o(a_kb),
    .en_xor_key_end_o(a_ke), .en_xor_lsb_end_o(a_lsb), .en_cipher_o(a_cip),
    .cipher_valid_o(a_cv), .en_tag_o(a_tag), .end_o(a_end)
  );

  ascon_ctrl_fsm_gen #(.ROUNDS_A(8), .ROUNDS_B(4), .BLK_W(4)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start), .decrypt_i(dec), .nb_ad_i(nad),
    .nb_pt_i(npt), .data_valid_i(valid), .data_ready_o(b_rdy), .busy_o(b_busy),
    .round_o(b_rnd), .data_sel_o(b_sel), .en_reg_state_o(b_reg),
    .en_xor_data_begin_o(b_xdb), .en_replace_o(b_rep), .en_xor_key_begin_o(b_kb),
    .en_xor_key_end_o(b_ke), .en_xor_lsb_end_o(b_lsb), .en_cipher_o(b_cip),
    .cipher_valid_o(b_cv), .en_tag_o(b_tag), .end_o(b_end)
  );

  assign obs_a = {a_busy, a_rdy, a_sel, a_reg, a_xdb, a_rep, a_kb, a_ke, a_lsb, a_cip,
                  a_cv, a_tag, a_end, a_rnd};
  assign obs_b = {b_busy, b_rdy, b_sel, b_reg, b_xdb, b_rep, b_kb, b_ke, b_lsb, b_cip,
                  b_cv, b_tag, b_end, b_rnd};

  task automatic chk(input string tag, input int c, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %0h expected %0h", tag, c, o, e);
    end
  endtask

  // Cycle 0 is the IDLE cycle with start_i high; traces are sampled 2 time units after
  // each rising edge. valid is low for cycles in [vlo, vhi); start re-pulses at cycle sp.
  // If rst_at >= 0, reset is raised mid-cycle rst_at and the run ends there.
  task automatic run(input logic d, input logic [3:0] na, input logic [3:0] np, input int n,
                     input int vlo, input int vhi, input int sp, input int rst_at);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      start = (c == 0) || (c == sp);
      dec   = d;
      nad   = na;
      npt   = np;
      valid = !(c >= vlo && c < vhi);
      #1;
      ta[c]  = obs_a;
      tbb[c] = obs_b;
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_a", c, 32'(obs_a), 32'd0);
        chk("rst_mid_b", c, 32'(obs_b), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        break;
      end
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    logic [16:0] e;
    rst = 1'b1; start = 1'b0; dec = 1'b0; valid = 1'b0; nad = '0; npt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 0, 32'(obs_a), 32'd0);
    chk("reset_b", 0, 32'(obs_b), 32'd0);
    rst = 1'b0;
    #1;

    // 1: nb_ad=1, nb_pt=3, valid always high, stray start at cycle 20.
    run(1'b0, 4'd1, 4'd3, 45, 0, 0, 20, -1);
    for (int c = 0; c <= 45; c++) begin
      e = '0;
      e[BBusy] = (c >= 1 && c <= 43);
      e[BRdy]  = (c == 13 || c == 19 || c == 25 || c == 31);
      e[BSel]  = (c >= 2 && c <= 42);
      e[BReg]  = (c >= 1 && c <= 42);
      e[BXdb]  = e[BRdy];
      e[BKb]   = (c == 31);
      e[BKe]   = (c == 12 || c == 42);
      e[BLsb]  = (c == 18);
      e[BCip]  = (c == 19 || c == 25 || c == 31);
      e[BCv]   = (c == 20 || c == 26 || c == 32);
      e[BTag]  = (c == 42);
      e[BEnd]  = (c == 43);
      if (c >= 1 && c <= 12)       e[3:0] = 4'(c - 1);
      else if (c >= 13 && c <= 30) e[3:0] = 4'(6 + (c - 13) % 6);
      else if (c >= 31 && c <= 42) e[3:0] = 4'(c - 31);
      chk("seq1", c, 32'(ta[c]), 32'(e));
    end

    // 2: no AD, single text block.
    run(1'b0, 4'd0, 4'd1, 27, 0, 0, -1, -1);
    chk("noad_c12_ke", 12, 32'(ta[12][BKe]), 32'd1);
    chk("noad_c12_lsb", 12, 32'(ta[12][BLsb]), 32'd1);
    e = '0;
    e[BBusy] = 1'b1; e[BRdy] = 1'b1; e[BSel] = 1'b1; e[BReg] = 1'b1;
    e[BXdb] = 1'b1; e[BKb] = 1'b1; e[BCip] = 1'b1;
    chk("noad_accept", 13, 32'(ta[13]), 32'(e));
    for (int c = 0; c <= 27; c++) chk("noad_end", c, 32'(ta[c][BEnd]), 32'(c == 25));

    // 3: decrypt, two text blocks.
    run(1'b1, 4'd0, 4'd2, 33, 0, 0, -1, -1);
    for (int c = 13; c <= 33; c++) begin
      chk("dec_replace", c, 32'(ta[c][BRep]), 32'(c == 13 || c == 19));
      chk("dec_noxor", c, 32'(ta[c][BXdb]), 32'd0);
    end
    chk("dec_end", 31, 32'(ta[31][BEnd]), 32'd1);

    // 4: valid held low for five AD_WAIT cycles, accept on the sixth.
    run(1'b0, 4'd1, 4'd1, 38, 0, 18, -1, -1);
    e = '0;
    e[BBusy] = 1'b1; e[BRdy] = 1'b1; e[BSel] = 1'b1; e[3:0] = 4'd6;
    for (int c = 13; c <= 17; c++) chk("stall_wait", c, 32'(ta[c]), 32'(e));
    e[BReg] = 1'b1; e[BXdb] = 1'b1;
    chk("stall_accept", 18, 32'(ta[18]), 32'(e));
    for (int c = 19; c <= 38; c++) chk("stall_end", c, 32'(ta[c][BEnd]), 32'(c == 36));

    // 5: reset mid-FIN_RND (cycle 35 of the first sequence), then a full fresh run.
    run(1'b0, 4'd1, 4'd3, 45, 0, 0, -1, 35);
    run(1'b0, 4'd0, 4'd1, 27, 0, 0, 5, -1);
    for (int c = 0; c <= 27; c++) chk("post_rst_end", c, 32'(ta[c][BEnd]), 32'(c == 25));
    chk("post_rst_round", 1, 32'(ta[1][3:0]), 32'd0);

    // 6: A=8,B=4 instance, nb_pt=0; valid held off two PT_WAIT cycles (9,10), so
    // INIT 1-8, accept at 11, FIN 12-18, end_o at 19.
    run(1'b0, 4'd0, 4'd0, 27, 9, 11, -1, -1);
    for (int c = 1; c <= 8; c++) chk("b_init_round", c, 32'(tbb[c][3:0]), 32'(c + 3));
    chk("b_wait_rdy", 9, 32'(tbb[9][BRdy]), 32'd1);
    chk("b_wait_noreg", 10, 32'(tbb[10][BReg]), 32'd0);
    chk("b_accept_kb", 11, 32'(tbb[11][BKb]), 32'd1);
    chk("b_accept_round", 11, 32'(tbb[11][3:0]), 32'd4);
    for (int c = 0; c <= 22; c++) chk("b_end", c, 32'(tbb[c][BEnd]), 32'(c == 19));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
